// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, reset PC and FSM encoding for the instruction fetch unit.
package instr_fetch_unit_pkg;
  localparam int ADDR_W_DEF     = 6;
  localparam int INSTR_W_DEF    = 30;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int RESET_PC_DEF   = 0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush; the head output holds its last value while empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  last_q, last_d;
  logic          full;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign dout  = empty ? last_q : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
    wr_d   = flush ? '0 : wr_q + AW'(push);
    rd_d   = flush ? '0 : rd_q + AW'(pop);
    cnt_d  = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    last_d = dout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  // The issuer reserves a slot before every read, so a push into a full FIFO is a design bug.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, 1-cycle memory read capture and fetch buffer to decode.
// Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_fetch_en,
  output logic [ADDR_W-1:0]  mem_pc,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               run,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [15:0]        stall_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     count;
  logic              empty, pop, push, room, issue;
  assign mem_fetch_en = 1'b1;
  assign instr_valid  = !empty;
  assign pop          = instr_valid && instr_ready;
  assign push         = inflight_q && !redirect;
  // Issue follows the next state so fetching starts in the same cycle run rises.
  always_comb begin
    state_d = run ? RUN :
              (redirect || state_q == IDLE) ? IDLE :
              (state_q == RUN || inflight_q) ? DRAIN : IDLE;
    room          = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop) < (CW+1)'(FIFO_DEPTH);
    issue         = state_d == RUN && (redirect || room);
    mem_pc        = redirect ? redirect_pc : pc_q;
    pc_d          = issue ? mem_pc + ADDR_W'(1) : mem_pc;
    inflight_d    = issue;
    inflight_pc_d = issue ? mem_pc : inflight_pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_pc_q, mem_instr}),
    .dout  ({instr_pc, instr_data}),
    .count (count),
    .empty (empty)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = redirect ? '0 :
              (state_q == RUN && !issue && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a 64x30 synchronous-read memory model.
module tb_instr_fetch_unit;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_fetch_en;
  logic [5:0]  mem_pc;
  logic [29:0] mem_instr = '0;
  logic        run, redirect, instr_ready;
  logic [5:0]  redirect_pc;
  logic        instr_valid;
  logic [29:0] instr_data;
  logic [5:0]  instr_pc;
  logic [15:0] stall_cnt;
  logic [29:0] mem [64];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_fetch_en (mem_fetch_en),
    .mem_pc       (mem_pc),
    .mem_instr    (mem_instr),
    .run          (run),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .stall_cnt    (stall_cnt)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = 30'h100 + 30'(i);

  always @(posedge clk) begin
    if (mem_fetch_en) mem_instr <= mem[mem_pc];
    else              mem[mem_pc] <= 30'h3FFFFFFF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input logic [5:0] p);
    check("head_valid", 32'(instr_valid), 32'd1);
    check("head_pc", 32'(instr_pc), 32'(p));
    check("head_data", 32'(instr_data), 32'h100 + 32'(p));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) tick;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data", 32'(instr_data), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_fetch_en", 32'(mem_fetch_en), 32'd1);
    check("rst_mem_pc", 32'(mem_pc), 32'd0);
    rst = 1'b0;
    tick;
    check("idle_valid", 32'(instr_valid), 32'd0);
    // sequential fetch: first valid two cycles after run rises
    run = 1'b1; instr_ready = 1'b1;
    tick;
    check("lat_valid_c1", 32'(instr_valid), 32'd0);
    for (int p = 0; p < 7; p++) begin
      tick;
      head(6'(p));
    end
    // backpressure: buffer fills with heads 6,7 and issue stops at pc 8
    instr_ready = 1'b0;
    repeat (5) begin
      tick;
      head(6'd6);
    end
    check("bp_mem_pc", 32'(mem_pc), 32'd8);
    check("bp_stall", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    instr_ready = 1'b1;
    for (int p = 7; p < 10; p++) begin
      tick;
      head(6'(p));
    end
    // redirect near the top of memory with a read in flight, then wrap
    redirect = 1'b1; redirect_pc = 6'd62;
    tick;
    redirect = 1'b0;
    check("redir_flush_valid", 32'(instr_valid), 32'd0);
    check("redir_stall_clr", 32'(stall_cnt), 32'd0);
    tick; head(6'd62);
    tick; head(6'd63);
    tick; head(6'd0);
    tick; head(6'd1);
    // redirect while the buffer is full
    instr_ready = 1'b0;
    tick;
    head(6'd1);
    redirect = 1'b1; redirect_pc = 6'h20; instr_ready = 1'b1;
    tick;
    redirect = 1'b0;
    check("full_redir_valid", 32'(instr_valid), 32'd0);
    tick;
    head(6'h20);
    check("stall_after_redir", 32'(stall_cnt), 32'd0);
    // stall counter over ten blocked cycles
    instr_ready = 1'b0;
    repeat (10) tick;
    head(6'h20);
    check("stall_10", 32'(stall_cnt), PERF ? 32'd10 : 32'd0);
    check("stall_mem_pc", 32'(mem_pc), 32'h22);
    instr_ready = 1'b1;
    tick;
    head(6'h21);
    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_fetch_en", 32'(mem_fetch_en), 32'd1);
    check("arst_mem_pc", 32'(mem_pc), 32'd0);
    check("arst_pc", 32'(instr_pc), 32'd0);
    check("arst_data", 32'(instr_data), 32'd0);
    check("arst_stall", 32'(stall_cnt), 32'd0);
    run = 1'b0; instr_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 30'h100 + 30'(i)) bad++;
    check("mem_unchanged", 32'(bad), 32'd0);
    tick;
    check("post_rst_valid", 32'(instr_valid), 32'd0);
    // restart, then drop run: in-flight read still delivered, no further issue
    run = 1'b1; instr_ready = 1'b1;
    tick;
    check("restart_c1", 32'(instr_valid), 32'd0);
    tick;
    head(6'd0);
    run = 1'b0;
    tick;
    head(6'd1);
    tick;
    check("drain_valid", 32'(instr_valid), 32'd0);
    check("drain_mem_pc", 32'(mem_pc), 32'd2);
    tick;
    check("idle_after_drain", 32'(instr_valid), 32'd0);
    check("final_fetch_en", 32'(mem_fetch_en), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
